// File: rtl/df_mac_sequencer.sv
// df_mac_sequencer
// Time-multiplexed FIR tap scheduler. It keeps a TAPS-deep delay line of
// input samples and a coefficient register file. It runs one tap per clock
// through an external shared multiplier and accumulates the products. Each
// accepted sample produces one saturated 8-bit result.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   sample_in       unsigned input sample, qualified by sample_valid
//   sample_ready    high while idle; a sample is taken on valid && ready
//   cfg_we/addr/coef coefficient write port (accepted only while idle)
//   cfg_err         one-cycle pulse after a write that arrived while busy
//   mul_coef/data   operands to the external multiplier
//   mul_prod        combinational product returned by the multiplier
//   y_out/y_valid/y_sat  filter result, new-result pulse, saturation flag
//
// state | meaning
// IDLE  | waiting for a sample, coefficient writes allowed
// MAC   | one tap per cycle, idx selects tap/coef, acc sums mul_prod
// DONE  | saturate acc into y_out, pulse y_valid, return to IDLE
module df_mac_sequencer #(
    parameter int TAPS  = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [4:0]       cfg_coef,
    output logic             cfg_err,
    output logic [4:0]       mul_coef,
    output logic [7:0]       mul_data,
    input  logic [7:0]       mul_prod,
    output logic [7:0]       y_out,
    output logic             y_valid,
    output logic             y_sat
);

    localparam int ACC_W = 8 + IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         tap_q  [TAPS];
    logic [7:0]         tap_d  [TAPS];
    logic [4:0]         coef_q [TAPS];
    logic [4:0]         coef_d [TAPS];
    logic [7:0]         y_out_q, y_out_d;
    logic               y_valid_q, y_valid_d;
    logic               y_sat_q, y_sat_d;
    logic               cfg_err_q, cfg_err_d;

    // Operand mux; the loop compare keeps out-of-range indices harmless
    // when TAPS is not a power of two.
    always_comb begin
        mul_coef = 5'd0;
        mul_data = 8'd0;
        if (state_q == ST_MAC) begin
            for (int k = 0; k < TAPS; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    mul_coef = coef_q[k];
                    mul_data = tap_q[k];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        tap_d     = tap_q;
        coef_d    = coef_q;
        y_out_d   = y_out_q;
        y_valid_d = 1'b0;
        y_sat_d   = y_sat_q;
        cfg_err_d = 1'b0;

        // Writes land in the same edge as a sample capture, so the pass that
        // starts on that edge already reads the new coefficient.
        if (cfg_we) begin
            if (state_q == ST_IDLE) begin
                for (int k = 0; k < TAPS; k++) begin
                    if (cfg_addr == IDX_W'(k)) begin
                        coef_d[k] = cfg_coef;
                    end
                end
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (sample_valid) begin
                    for (int k = TAPS - 1; k > 0; k--) begin
                        tap_d[k] = tap_q[k-1];
                    end
                    tap_d[0] = sample_in;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + {{IDX_W{1'b0}}, mul_prod};
                if (idx_q == IDX_W'(TAPS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                y_sat_d   = (acc_q > ACC_W'(255));
                y_out_d   = (acc_q > ACC_W'(255)) ? 8'hFF : acc_q[7:0];
                y_valid_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            y_out_q   <= 8'd0;
            y_valid_q <= 1'b0;
            y_sat_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                tap_q[k]  <= 8'd0;
                coef_q[k] <= 5'd0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            y_out_q   <= y_out_d;
            y_valid_q <= y_valid_d;
            y_sat_q   <= y_sat_d;
            cfg_err_q <= cfg_err_d;
            for (int k = 0; k < TAPS; k++) begin
                tap_q[k]  <= tap_d[k];
                coef_q[k] <= coef_d[k];
            end
        end
    end

    assign sample_ready = (state_q == ST_IDLE);
    assign y_out        = y_out_q;
    assign y_valid      = y_valid_q;
    assign y_sat        = y_sat_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_df_mac_sequencer.sv
// Directed bench for df_mac_sequencer (TAPS=4). The external multiplier is
// modelled as (data*coef)>>5. Expected values are hand-computed constants.
module tb_df_mac_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [4:0] cfg_coef;
    logic       cfg_err;
    logic [4:0] mul_coef;
    logic [7:0] mul_data;
    logic [7:0] mul_prod;
    logic [7:0] y_out;
    logic       y_valid;
    logic       y_sat;

    int n_vec = 0;
    int n_err = 0;

    df_mac_sequencer #(.TAPS(4), .IDX_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_coef    (cfg_coef),
        .cfg_err     (cfg_err),
        .mul_coef    (mul_coef),
        .mul_data    (mul_data),
        .mul_prod    (mul_prod),
        .y_out       (y_out),
        .y_valid     (y_valid),
        .y_sat       (y_sat)
    );

    logic [12:0] full_prod;
    assign full_prod = {5'd0, mul_data} * {8'd0, mul_coef};
    assign mul_prod  = full_prod[12:5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_valid = 1'b0;
        cfg_we = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_coef(input logic [1:0] a, input logic [4:0] c);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_coef = c;
        tick();
        cfg_we = 1'b0;
    endtask

    // Called just after an accept edge; returns when y_valid is seen.
    task automatic wait_y(output logic [7:0] y, output logic s, output int cyc);
        cyc = 0;
        while (!y_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        y = y_out;
        s = y_sat;
    endtask

    task automatic send(input logic [7:0] v, output logic [7:0] y, output logic s,
                        output int cyc);
        sample_in = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        wait_y(y, s, cyc);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({sample_ready, y_valid, y_sat, cfg_err, y_out, mul_coef, mul_data} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 8'd0}) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%b yv=%b sat=%b err=%b y=%0d mc=%0d md=%0d, required 1 0 0 0 0 0 0",
                     sample_ready, y_valid, y_sat, cfg_err, y_out, mul_coef, mul_data);
        end
    endtask

    task automatic test_latency();
        int cyc;
        int low;
        sample_in = 8'd200;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        cyc = 0;
        low = 0;
        while (!y_valid && cyc < 20) begin
            if (!sample_ready) low++;
            tick();
            cyc++;
        end
        n_vec++;
        if (cyc !== 5) begin
            n_err++;
            $display("FAIL latency: got %0d cycles, required 5", cyc);
        end
        n_vec++;
        if (low !== 5) begin
            n_err++;
            $display("FAIL ready_low: got %0d cycles, required 5", low);
        end
        n_vec++;
        if ({y_out, y_sat, sample_ready} !== {8'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL zero_coef_result: y=%0d sat=%b ready=%b, required 0 0 1",
                     y_out, y_sat, sample_ready);
        end
        tick();
        n_vec++;
        if ({y_valid, y_out} !== {1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL y_valid_pulse: yv=%b y=%0d, required 0 0", y_valid, y_out);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] y;
        logic s;
        int cyc;
        do_reset();
        for (int k = 0; k < 4; k++) write_coef(2'(k), 5'd31);
        send(8'd255, y, s, cyc);
        n_vec++;
        if ({y, s} !== {8'd247, 1'b0} || cyc !== 5) begin
            n_err++;
            $display("FAIL sat_first: y=%0d sat=%b cyc=%0d, required 247 0 5", y, s, cyc);
        end
        send(8'd255, y, s, cyc);
        n_vec++;
        if ({y, s} !== {8'd255, 1'b1}) begin
            n_err++;
            $display("FAIL sat_second: y=%0d sat=%b, required 255 1", y, s);
        end
    endtask

    task automatic test_delay_line();
        logic [7:0] y;
        logic s;
        int cyc;
        logic [7:0] exp_md [4];
        exp_md = '{8'd10, 8'd100, 8'd0, 8'd0};
        do_reset();
        write_coef(2'd0, 5'd16);
        write_coef(2'd1, 5'd16);
        send(8'd100, y, s, cyc);
        n_vec++;
        if ({y, s} !== {8'd50, 1'b0}) begin
            n_err++;
            $display("FAIL taps_first: y=%0d sat=%b, required 50 0", y, s);
        end
        sample_in = 8'd10;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (mul_data !== exp_md[k]) begin
                n_err++;
                $display("FAIL mul_data[%0d]: got %0d, required %0d", k, mul_data, exp_md[k]);
            end
            tick();
        end
        wait_y(y, s, cyc);
        n_vec++;
        if ({y, s} !== {8'd55, 1'b0} || cyc !== 1) begin
            n_err++;
            $display("FAIL taps_second: y=%0d sat=%b cyc=%0d, required 55 0 1", y, s, cyc);
        end
    endtask

    task automatic test_cfg_busy();
        logic [7:0] y;
        logic s;
        int cyc;
        do_reset();
        write_coef(2'd0, 5'd8);
        sample_in = 8'd64;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        cfg_we = 1'b1;
        cfg_addr = 2'd0;
        cfg_coef = 5'd31;
        tick();
        cfg_we = 1'b0;
        n_vec++;
        if (cfg_err !== 1'b1) begin
            n_err++;
            $display("FAIL cfg_err_pulse: got %b, required 1", cfg_err);
        end
        tick();
        n_vec++;
        if (cfg_err !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_err_clear: got %b, required 0", cfg_err);
        end
        wait_y(y, s, cyc);
        n_vec++;
        if ({y, s} !== {8'd16, 1'b0}) begin
            n_err++;
            $display("FAIL cfg_busy_ignored: y=%0d sat=%b, required 16 0", y, s);
        end
        // Write and sample on the same edge in IDLE.
        cfg_we = 1'b1;
        cfg_addr = 2'd0;
        cfg_coef = 5'd31;
        sample_in = 8'd64;
        sample_valid = 1'b1;
        tick();
        cfg_we = 1'b0;
        sample_valid = 1'b0;
        n_vec++;
        if (cfg_err !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_idle_no_err: got %b, required 0", cfg_err);
        end
        wait_y(y, s, cyc);
        n_vec++;
        if ({y, s} !== {8'd62, 1'b0}) begin
            n_err++;
            $display("FAIL cfg_same_edge: y=%0d sat=%b, required 62 0", y, s);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_y [4];
        exp_y = '{8'd0, 8'd0, 8'd46, 8'd93};
        do_reset();
        write_coef(2'd1, 5'd31);
        for (int i = 0; i < 24; i++) begin
            sample_in = 8'(8 * i);
            sample_valid = 1'b1;
            tick();
            n_vec++;
            if (y_valid !== ((i % 6) == 5)) begin
                n_err++;
                $display("FAIL b2b_valid[%0d]: got %b, required %b", i, y_valid, (i % 6) == 5);
            end
            if ((i % 6) == 5) begin
                n_vec++;
                if (y_out !== exp_y[i/6]) begin
                    n_err++;
                    $display("FAIL b2b_y[%0d]: got %0d, required %0d", i / 6, y_out, exp_y[i/6]);
                end
            end
        end
        sample_valid = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        logic [7:0] y;
        logic s;
        int cyc;
        int seen;
        do_reset();
        write_coef(2'd0, 5'd31);
        send(8'd100, y, s, cyc);
        n_vec++;
        if (y !== 8'd96) begin
            n_err++;
            $display("FAIL abort_setup: y=%0d, required 96", y);
        end
        sample_in = 8'd200;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({sample_ready, y_out, y_valid} !== {1'b1, 8'd0, 1'b0}) begin
            n_err++;
            $display("FAIL abort_state: ready=%b y=%0d yv=%b, required 1 0 0",
                     sample_ready, y_out, y_valid);
        end
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (y_valid) seen++;
            tick();
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL abort_no_valid: got %0d pulses, required 0", seen);
        end
        send(8'd50, y, s, cyc);
        n_vec++;
        if ({y, s} !== {8'd0, 1'b0} || cyc !== 5) begin
            n_err++;
            $display("FAIL abort_coef_clear: y=%0d sat=%b cyc=%0d, required 0 0 5", y, s, cyc);
        end
        write_coef(2'd2, 5'd31);
        send(8'd7, y, s, cyc);
        n_vec++;
        if (y !== 8'd0) begin
            n_err++;
            $display("FAIL abort_taps_clear: y=%0d, required 0", y);
        end
    endtask

    initial begin
        rst = 1'b1;
        sample_in = 8'd0;
        sample_valid = 1'b0;
        cfg_we = 1'b0;
        cfg_addr = 2'd0;
        cfg_coef = 5'd0;
        test_reset();
        test_latency();
        test_saturation();
        test_delay_line();
        test_cfg_busy();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
